// File: rtl/alu_mc.sv
// alu_mc: handshaked, registered integer ALU with status flags.
//   Accepts one operation per in_valid/in_ready transfer. The result, zero,
//   ovf and illegal are held in registers. They are presented on an
//   out_valid/out_ready channel, and that channel may be stalled by writeback.
//   Optional macro ALU_MC_MUL_EN adds an iterative shift-add multiplier on
//   opcode C. Without it, opcode C is reserved.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid / in_ready         request handshake
//   alu_control, srcA, srcB     opcode and operands, captured at accept
//   out_valid / out_ready       result handshake
//   alu_result, zero, ovf,      registered result and status flags
//   illegal
module alu_mc #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_control,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_result,
   output logic             zero,
   output logic             ovf,
   output logic             illegal
);

   localparam int unsigned SHW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
`ifdef ALU_MC_MUL_EN
      BUSY = 2'd2,
`endif
      DONE = 2'd1
   } state_t;

   state_t state, state_n;

   logic             accept;
   logic             load;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] sum_c, diff_c, res_c;
   logic             ovf_c, ill_c;

`ifdef ALU_MC_MUL_EN
   logic             start, step, fin;
   logic [WIDTH-1:0] ma, mb, prod, prod_n;
   logic [SHW-1:0]   cnt;
`endif

   // Handshake: a held result must be drained before a new request can enter.
   assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
   assign out_valid = (state == DONE);
   assign accept    = in_valid & in_ready;

   // Single-cycle operation result and flags, evaluated from the live inputs.
   always_comb begin
      shamt  = srcB[SHW-1:0];
      sum_c  = srcA + srcB;
      diff_c = srcA - srcB;
      res_c  = '0;
      ovf_c  = 1'b0;
      ill_c  = 1'b0;
      case (alu_control)
         4'h0: res_c = srcA & srcB;
         4'h1: res_c = srcA | srcB;
         4'h2: begin
            res_c = sum_c;
            ovf_c = (srcA[WIDTH-1] == srcB[WIDTH-1]) && (sum_c[WIDTH-1] != srcA[WIDTH-1]);
         end
         4'h3: res_c = WIDTH'($signed(srcA) < $signed(srcB));
         4'h4: res_c = srcA & ~srcB;
         4'h5: res_c = ~(srcA | srcB);
         4'h6: begin
            res_c = diff_c;
            ovf_c = (srcA[WIDTH-1] != srcB[WIDTH-1]) && (diff_c[WIDTH-1] != srcA[WIDTH-1]);
         end
         4'h7: res_c = WIDTH'(srcA < srcB);
         4'h8: res_c = srcA << shamt;
         4'h9: res_c = srcA >> shamt;
         4'hA: res_c = WIDTH'($signed(srcA) >>> shamt);
         4'hB: res_c = srcA ^ srcB;
         default: ill_c = 1'b1;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state and datapath controls.
   always_comb begin
      state_n = state;
      load    = 1'b0;
`ifdef ALU_MC_MUL_EN
      start   = 1'b0;
      step    = 1'b0;
      fin     = 1'b0;
`endif
      case (state)
         IDLE, DONE: begin
            if (accept) begin
`ifdef ALU_MC_MUL_EN
               if (alu_control == 4'hC) begin
                  start   = 1'b1;
                  state_n = BUSY;
               end else begin
                  load    = 1'b1;
                  state_n = DONE;
               end
`else
               load    = 1'b1;
               state_n = DONE;
`endif
            end else if ((state == DONE) && out_ready) begin
               state_n = IDLE;
            end
         end
`ifdef ALU_MC_MUL_EN
         BUSY: begin
            step = 1'b1;
            if (cnt == SHW'(WIDTH - 1)) begin
               fin     = 1'b1;
               state_n = DONE;
            end
         end
`endif
         default: state_n = IDLE;
      endcase
   end

`ifdef ALU_MC_MUL_EN
   assign prod_n = prod + (mb[0] ? ma : '0);

   // Shift-add multiplier: one multiplier bit per cycle, LSB first.
   always_ff @(posedge clk) begin
      if (rst) begin
         ma   <= '0;
         mb   <= '0;
         prod <= '0;
         cnt  <= '0;
      end else if (start) begin
         ma   <= srcA;
         mb   <= srcB;
         prod <= '0;
         cnt  <= '0;
      end else if (step) begin
         ma   <= ma << 1;
         mb   <= mb >> 1;
         prod <= prod_n;
         cnt  <= cnt + SHW'(1);
      end
   end
`endif

   // Result registers: written only when a result is completed, so nothing
   // partial is ever presented.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_result <= '0;
         zero       <= 1'b0;
         ovf        <= 1'b0;
         illegal    <= 1'b0;
      end else if (load) begin
         alu_result <= res_c;
         zero       <= (res_c == '0);
         ovf        <= ovf_c;
         illegal    <= ill_c;
      end
`ifdef ALU_MC_MUL_EN
      else if (fin) begin
         alu_result <= prod_n;
         zero       <= (prod_n == '0);
         ovf        <= 1'b0;
         illegal    <= 1'b0;
      end
`endif
   end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed plus random checks of alu_mc against an arithmetic model.
module tb_alu_mc;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_control;
   logic [31:0] srcA, srcB;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_result;
   logic        zero, ovf, illegal;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_mc #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_control(alu_control), .srcA(srcA), .srcB(srcB),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_result(alu_result), .zero(zero), .ovf(ovf), .illegal(illegal)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model from plain signed/unsigned integer arithmetic.
   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic o, output logic il);
      longint sa, sb, s;
      longint unsigned p;
      int sh;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = int'(b % 32);
      r = 32'h0; o = 1'b0; il = 1'b0;
      case (op)
         4'h0: r = a & b;
         4'h1: r = a | b;
         4'h2: begin s = sa + sb; r = 32'(s); o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         4'h3: r = (sa < sb) ? 32'd1 : 32'd0;
         4'h4: r = a & ~b;
         4'h5: r = ~(a | b);
         4'h6: begin s = sa - sb; r = 32'(s); o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         4'h7: r = (a < b) ? 32'd1 : 32'd0;
         4'h8: r = 32'(longint'(a) * (64'sd1 <<< sh));
         4'h9: r = 32'(longint'(a) / (64'sd1 <<< sh));
         4'hA: r = 32'(sa >>> sh);
         4'hB: r = a ^ b;
`ifdef ALU_MC_MUL_EN
         4'hC: begin p = 64'(a) * 64'(b); r = 32'(p); end
`endif
         default: il = 1'b1;
      endcase
   endfunction

   // Issue a single-cycle op (DUT must be ready) and check it one cycle later.
   task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic o, il;
      in_valid = 1'b1; alu_control = op; srcA = a; srcB = b;
      #1;
      chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      model(op, a, b, r, o, il);
      tick();
      chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".result"}, alu_result, r);
      chk({tag, ".zero"}, 32'(zero), 32'(r == 32'h0));
      chk({tag, ".ovf"}, 32'(ovf), 32'(o));
      chk({tag, ".illegal"}, 32'(illegal), 32'(il));
   endtask

   initial begin
      int cyc;
      int seen;
      logic [3:0] op;
      logic [31:0] a, b;

      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      alu_control = 4'h2; srcA = 32'd7; srcB = 32'd9;

      // Reset with a request pending
      tick(); tick();
      rst = 1'b0; in_valid = 1'b0;
      #1;
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.result", alu_result, 32'h0);
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk("rst.zero", 32'(zero), 32'd0);
      chk("rst.illegal", 32'(illegal), 32'd0);

      // Back-to-back ADD then SUB on consecutive cycles
      single("add_ovf", 4'h2, 32'h7FFFFFFF, 32'h1);
      chk("add_ovf.val", alu_result, 32'h80000000);
      chk("add_ovf.flag", 32'(ovf), 32'd1);
      single("sub_zero", 4'h6, 32'd5, 32'd5);
      chk("sub_zero.flag", 32'(zero), 32'd1);

      // Compares and shifts, still back-to-back
      single("slt", 4'h3, 32'h80000000, 32'h1);
      chk("slt.val", alu_result, 32'h1);
      single("sltu", 4'h7, 32'h80000000, 32'h1);
      chk("sltu.val", alu_result, 32'h0);
      single("sra", 4'hA, 32'h80000000, 32'h24);
      chk("sra.val", alu_result, 32'hF8000000);
      single("srl", 4'h9, 32'h80000000, 32'h24);
      chk("srl.val", alu_result, 32'h08000000);
      single("sub_ovf", 4'h6, 32'h80000000, 32'h1);
      single("slt_ovf", 4'h3, 32'h7FFFFFFF, 32'h80000000);

      // Reserved opcodes
      single("rsv_e", 4'hE, 32'h1234, 32'h5678);
      chk("rsv_e.val", alu_result, 32'h0);
      chk("rsv_e.ill", 32'(illegal), 32'd1);
`ifndef ALU_MC_MUL_EN
      single("rsv_c", 4'hC, 32'hFFFFFFFF, 32'h3);
      chk("rsv_c.ill", 32'(illegal), 32'd1);
`endif

      // Random single-cycle ops back-to-back
      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 15));
`ifdef ALU_MC_MUL_EN
         if (op == 4'hC) op = 4'hB;
`endif
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) a = 32'h7FFFFFFF + 32'($urandom_range(0, 2));
         if ($urandom_range(0, 3) == 0) b = a;
         single($sformatf("rnd%0d", i), op, a, b);
      end

      // Drain to IDLE
      in_valid = 1'b0;
      tick();
      chk("drain.out_valid", 32'(out_valid), 32'd0);

      // Backpressure: hold XOR result for 3 cycles while a request waits
      out_ready = 1'b0;
      single("xor", 4'hB, 32'hFF00FF00, 32'h0F0F0F0F);
      chk("xor.val", alu_result, 32'hF00FF00F);
      alu_control = 4'h2; srcA = 32'h1; srcB = 32'h1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hold.in_ready", 32'(in_ready), 32'd0);
         tick();
         chk("hold.out_valid", 32'(out_valid), 32'd1);
         chk("hold.result", alu_result, 32'hF00FF00F);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk("release.out_valid", 32'(out_valid), 32'd0);
      chk("release.result", alu_result, 32'hF00FF00F);

`ifdef ALU_MC_MUL_EN
      // MUL latency WIDTH+1, busy blocks input
      in_valid = 1'b1; alu_control = 4'hC; srcA = 32'hFFFFFFFF; srcB = 32'h3;
      tick();
      in_valid = 1'b0; srcA = 32'h0; srcB = 32'h0;
      cyc = 0;
      for (int i = 0; i < 40; i++) begin
         cyc++;
         if (out_valid) break;
         chk("mul.busy_ready", 32'(in_ready), 32'd0);
         tick();
      end
      chk("mul.latency", 32'(cyc), 32'd33);
      chk("mul.result", alu_result, 32'hFFFFFFFD);
      chk("mul.illegal", 32'(illegal), 32'd0);
      tick();

      // Random multiply
      a = $urandom; b = $urandom;
      in_valid = 1'b1; alu_control = 4'hC; srcA = a; srcB = b;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) break;
         tick();
      end
      chk("mul_rnd.out_valid", 32'(out_valid), 32'd1);
      chk("mul_rnd.result", alu_result, 32'(64'(a) * 64'(b)));
      tick();

      // Reset during BUSY discards the operation
      in_valid = 1'b1; alu_control = 4'hC; srcA = 32'hFFFFFFFF; srcB = 32'h3;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) seen++;
         tick();
      end
      chk("mul_abort.out_valid_seen", 32'(seen), 32'd0);
      chk("mul_abort.result", alu_result, 32'h0);
      chk("mul_abort.in_ready", 32'(in_ready), 32'd1);
`else
      cyc = 0;
      seen = 0;
`endif

      // Reset while a result is held in DONE
      out_ready = 1'b0;
      single("pre_rst", 4'h1, 32'hA5A5_0000, 32'h0000_5A5A);
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("done_rst.out_valid", 32'(out_valid), 32'd0);
      chk("done_rst.result", alu_result, 32'h0);
      out_ready = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
